mem_native_arbiter: RTL and testbench
=====================================

Name: mem_native_arbiter

Overview:
- Shares one PicoRV32-style native memory port (valid/ready/addr/wdata/wstrb/instr/rdata) among NUM_MASTERS requesters, e.g. the CPU core plus a DMA or debug loader in the test system.
- Serialises whole transactions using round-robin or fixed-priority arbitration.
- Registers all slave-side request signals.
- Has an optional response-timeout watchdog that completes a stuck transaction with a poison value.

Parameters:
NUM_MASTERS, 2, number of requesters (2..8)
ARB_MODE, 0, 0 = round-robin, 1 = fixed priority (lowest index wins)
TIMEOUT_CYCLES, 0, slave wait limit in cycles while BUSY; 0 disables the watchdog (max 65535)

Ports:
clk  in  1  clock, all logic on rising edge
reset  in  1  asynchronous, active-high reset
m_mem_valid  in  NUM_MASTERS  request valid per master
m_mem_instr  in  NUM_MASTERS  instruction-fetch flag per master
m_mem_ready  out  NUM_MASTERS  one-cycle completion pulse per master
m_mem_addr  in  32*NUM_MASTERS  master i at [32i+31:32i]
m_mem_wdata  in  32*NUM_MASTERS  write data, same packing
m_mem_wstrb  in  4*NUM_MASTERS  byte strobes; 0 means read
m_mem_rdata  out  32  shared read data; meaningful only while the owner's m_mem_ready is high
s_mem_valid  out  1  request to slave
s_mem_instr  out  1  latched instr flag
s_mem_ready  in  1  slave completion
s_mem_addr  out  32  latched address
s_mem_wdata  out  32  latched write data
s_mem_wstrb  out  4  latched strobes
s_mem_rdata  in  32  slave read data
grant  out  GNT_W  current or last owner index; GNT_W = max(1, clog2(NUM_MASTERS))
busy  out  1  high in BUSY and DONE
timeout_err  out  1  sticky watchdog flag

Behaviour:
- Reset (asynchronous): state IDLE. All outputs are 0: s_mem_valid, s_mem_instr, s_mem_addr, s_mem_wdata, s_mem_wstrb, m_mem_ready, m_mem_rdata, grant, busy, timeout_err. The RR pointer is set to NUM_MASTERS-1, so master 0 wins first.
- FSM states: IDLE, BUSY, DONE.
- IDLE:
  - If any m_mem_valid is high, select a winner. In RR mode, search from pointer+1 with wrap. In fixed mode, take the lowest index.
  - On that edge: latch the winner's addr/wdata/wstrb/instr into the s_mem_* registers, set grant, set s_mem_valid=1, go to BUSY.
  - RR pointer is updated to the winner.
- BUSY:
  - s_mem_* outputs are held constant.
  - When s_mem_ready=1: next edge sets s_mem_valid=0, m_mem_rdata=s_mem_rdata (latched even for writes), m_mem_ready[grant]=1, go to DONE.
- DONE:
  - m_mem_ready[grant] is high for exactly this one cycle.
  - Next edge clears m_mem_ready and goes to IDLE.
  - Masters sampled in IDLE have therefore already seen ready, so a stale valid is never re-granted.
- Latency: m_mem_valid at edge t → s_mem_valid at t+1. Slave ready at edge k → m_mem_ready at k+1. Minimum 3 cycles from request to next arbitration.
- Requests from non-granted masters wait; their m_mem_ready stays 0. Only one m_mem_ready bit is ever high.
- A master dropping valid mid-transaction is a protocol violation. There is no abort: the transaction completes and the ready pulse is still issued.
- Watchdog (TIMEOUT_CYCLES>0):
  - A 16-bit counter clears on entry to BUSY and increments each BUSY cycle with s_mem_ready=0.
  - When the count reaches TIMEOUT_CYCLES, the next edge does the normal completion but with m_mem_rdata=32'hDEAD_BEEF, and sets timeout_err=1.
  - timeout_err clears only on reset.
  - If s_mem_ready coincides with the limit cycle, the slave wins: real data is returned, no error.
- s_mem_ready while not BUSY is ignored.
- Reset asserted mid-transaction: immediate return to reset values; the pending transaction is dropped.

Decomposition:
- Package mem_arb_pkg: state enum (IDLE/BUSY/DONE), ARB_RR/ARB_FIXED constants, TIMEOUT_RDATA = 32'hDEAD_BEEF, GNT_W function.
- Sub-module mem_arb_rr_pick: combinational picker. Inputs: request vector, pointer, mode. Outputs: winner index and any_req.

Test Plan:
- Master 0 read, addr 0x100; slave ready 2 cycles after s_mem_valid with rdata 0x12345678 → s_mem_addr=0x100, wstrb=0; m_mem_ready[0] pulses 1 cycle with rdata 0x12345678; m_mem_ready[1]=0 throughout.
- Master 1 write, addr 0x200, wdata 0xAABBCCDD, wstrb 4'b0011, instr=0 → slave sees exactly those values; grant=1; one m_mem_ready[1] pulse.
- Both masters hold valid continuously, slave always ready, ARB_MODE=0 → grant sequence 0,1,0,1 over 4 transactions; each master gets 2 ready pulses. With ARB_MODE=1 → grant 0,0,0,0.
- TIMEOUT_CYCLES=8, slave never ready → s_mem_valid falls after 8 BUSY cycles; m_mem_ready pulse with rdata 0xDEADBEEF; timeout_err=1 and stays 1 through later good transactions.
- Slave ready on exactly the 8th wait cycle with rdata 0x55AA55AA → data 0x55AA55AA returned; timeout_err stays 0.
- Reset asserted mid-BUSY → s_mem_valid, busy and m_mem_ready go 0 immediately without a clock edge. After release with both masters valid, master 0 is granted first.

Source files
------------

// File: rtl/mem_native_arbiter_pkg.sv
// Shared types and constants for the native memory-port arbiter.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } arb_state_e;

  localparam int ARB_RR    = 0;
  localparam int ARB_FIXED = 1;

  localparam logic [31:0] TIMEOUT_RDATA = 32'hDEAD_BEEF;

  // Grant index width; a two-master arbiter still needs one bit.
  function automatic int gnt_w(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mem_native_arbiter_if.sv
// PicoRV32-style native memory bus with N requester lanes and one shared rdata.
interface mem_native_arbiter_if #(
  parameter int N = 1
) ();
  logic [N-1:0]    valid;
  logic [N-1:0]    instr;
  logic [N-1:0]    ready;
  logic [32*N-1:0] addr;
  logic [32*N-1:0] wdata;
  logic [4*N-1:0]  wstrb;
  logic [31:0]     rdata;

  modport master (
    output valid, instr, addr, wdata, wstrb,
    input  ready, rdata
  );

  modport slave (
    input  valid, instr, addr, wdata, wstrb,
    output ready, rdata
  );
endinterface

// File: rtl/mem_native_arbiter_rr_pick.sv
// Combinational winner selection: round-robin from ptr+1 or lowest-index-first.
module mem_arb_rr_pick
  import mem_arb_pkg::*;
#(
  parameter  int N  = 2,
  localparam int GW = gnt_w(N)
) (
  input  logic [N-1:0]  req_i,
  input  logic [GW-1:0] ptr_i,
  input  logic          fixed_i,
  output logic [GW-1:0] winner_o,
  output logic          any_req_o
);

  logic [GW-1:0] win_s;
  logic          hit_s;
  int            best_s;

  // Keep the requester with the smallest rank: its index (fixed) or its distance past ptr (RR).
  always_comb begin
    win_s  = '0;
    hit_s  = 1'b0;
    best_s = N;
    for (int j = 0; j < N; j++) begin
      hit_s  = req_i[j] && (fixed_i ? (j < best_s)
                                    : (((j + N - 1 - int'(ptr_i)) % N) < best_s));
      best_s = hit_s ? (fixed_i ? j : ((j + N - 1 - int'(ptr_i)) % N)) : best_s;
      win_s  = hit_s ? GW'(j) : win_s;
    end
  end

  assign winner_o  = win_s;
  assign any_req_o = |req_i;

endmodule

// File: rtl/mem_native_arbiter.sv
// Serialises whole native-bus transactions from NUM_MASTERS requesters onto one
// slave port, with registered slave-side request and an optional timeout watchdog.
module mem_native_arbiter
  import mem_arb_pkg::*;
#(
  parameter  int NUM_MASTERS    = 2,
  parameter  int ARB_MODE       = ARB_RR,
  parameter  int TIMEOUT_CYCLES = 0,
  localparam int GNT_W          = gnt_w(NUM_MASTERS)
) (
  input  logic                 clk,
  input  logic                 reset,
  mem_native_arbiter_if.slave  m_bus,
  mem_native_arbiter_if.master s_bus,
  output logic [GNT_W-1:0]     grant,
  output logic                 busy,
  output logic                 timeout_err
);

  arb_state_e             state_q;
  logic [GNT_W-1:0]       grant_q;
  logic [GNT_W-1:0]       ptr_q;
  logic [NUM_MASTERS-1:0] m_ready_q;
  logic [31:0]            m_rdata_q;
  logic                   s_valid_q;
  logic                   s_instr_q;
  logic [31:0]            s_addr_q;
  logic [31:0]            s_wdata_q;
  logic [3:0]             s_wstrb_q;
  logic                   busy_q;
  logic                   terr_q;
  logic [15:0]            wd_cnt_q;

  logic [GNT_W-1:0]       pick_s;
  logic                   any_req_s;
  logic [31:0]            sel_addr_s;
  logic [31:0]            sel_wdata_s;
  logic [3:0]             sel_wstrb_s;
  logic                   sel_instr_s;
  logic [NUM_MASTERS-1:0] ready_oh_s;
  logic                   wd_hit_s;

  mem_arb_rr_pick #(.N(NUM_MASTERS)) u_pick (
    .req_i     (m_bus.valid),
    .ptr_i     (ptr_q),
    .fixed_i   (ARB_MODE == ARB_FIXED),
    .winner_o  (pick_s),
    .any_req_o (any_req_s)
  );

  // Mux out the picked master's request fields.
  always_comb begin
    sel_addr_s  = 32'h0000_0000;
    sel_wdata_s = 32'h0000_0000;
    sel_wstrb_s = 4'b0000;
    sel_instr_s = 1'b0;
    for (int j = 0; j < NUM_MASTERS; j++) begin
      sel_addr_s  = (pick_s == GNT_W'(j)) ? m_bus.addr[32*j +: 32]  : sel_addr_s;
      sel_wdata_s = (pick_s == GNT_W'(j)) ? m_bus.wdata[32*j +: 32] : sel_wdata_s;
      sel_wstrb_s = (pick_s == GNT_W'(j)) ? m_bus.wstrb[4*j +: 4]   : sel_wstrb_s;
      sel_instr_s = (pick_s == GNT_W'(j)) ? m_bus.instr[j]          : sel_instr_s;
    end
  end

  // One-hot completion vector for the current owner.
  always_comb begin
    ready_oh_s = '0;
    for (int j = 0; j < NUM_MASTERS; j++) begin
      ready_oh_s[j] = (grant_q == GNT_W'(j));
    end
  end

  // The limit is hit in the BUSY cycle whose un-ready edge would bring the count to TIMEOUT_CYCLES.
  assign wd_hit_s = (TIMEOUT_CYCLES != 0) && (wd_cnt_q == 16'(TIMEOUT_CYCLES - 1));

  // Transaction FSM with all outputs registered.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      grant_q   <= '0;
      ptr_q     <= GNT_W'(NUM_MASTERS - 1);
      m_ready_q <= '0;
      m_rdata_q <= 32'h0000_0000;
      s_valid_q <= 1'b0;
      s_instr_q <= 1'b0;
      s_addr_q  <= 32'h0000_0000;
      s_wdata_q <= 32'h0000_0000;
      s_wstrb_q <= 4'b0000;
      busy_q    <= 1'b0;
      terr_q    <= 1'b0;
      wd_cnt_q  <= 16'h0000;
    end else begin
      case (state_q)
        IDLE: begin
          if (any_req_s) begin
            grant_q   <= pick_s;
            ptr_q     <= pick_s;
            s_addr_q  <= sel_addr_s;
            s_wdata_q <= sel_wdata_s;
            s_wstrb_q <= sel_wstrb_s;
            s_instr_q <= sel_instr_s;
            s_valid_q <= 1'b1;
            busy_q    <= 1'b1;
            wd_cnt_q  <= 16'h0000;
            state_q   <= BUSY;
          end
        end
        BUSY: begin
          if (s_bus.ready[0]) begin
            s_valid_q <= 1'b0;
            m_rdata_q <= s_bus.rdata;
            m_ready_q <= ready_oh_s;
            state_q   <= DONE;
          end else if (wd_hit_s) begin
            s_valid_q <= 1'b0;
            m_rdata_q <= TIMEOUT_RDATA;
            m_ready_q <= ready_oh_s;
            terr_q    <= 1'b1;
            state_q   <= DONE;
          end else begin
            wd_cnt_q  <= wd_cnt_q + 16'd1;
          end
        end
        DONE: begin
          m_ready_q <= '0;
          busy_q    <= 1'b0;
          state_q   <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign s_bus.valid = s_valid_q;
  assign s_bus.instr = s_instr_q;
  assign s_bus.addr  = s_addr_q;
  assign s_bus.wdata = s_wdata_q;
  assign s_bus.wstrb = s_wstrb_q;
  assign m_bus.ready = m_ready_q;
  assign m_bus.rdata = m_rdata_q;
  assign grant       = grant_q;
  assign busy        = busy_q;
  assign timeout_err = terr_q;

endmodule

// File: tb/tb_mem_native_arbiter.sv
// Directed + randomized bench: a round-robin arbiter with watchdog and a fixed-priority
// twin fed the same stimulus, checked against a transaction-level arbitration model.
module tb_mem_native_arbiter;
  import mem_arb_pkg::*;

  localparam int N   = 2;
  localparam int TMO = 8;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  mem_native_arbiter_if #(.N(N)) ma ();
  mem_native_arbiter_if #(.N(1)) sa ();
  mem_native_arbiter_if #(.N(N)) mb ();
  mem_native_arbiter_if #(.N(1)) sb ();

  logic [0:0] grant_a, grant_b;
  logic       busy_a, busy_b, terr_a, terr_b;

  mem_native_arbiter #(.NUM_MASTERS(N), .ARB_MODE(ARB_RR), .TIMEOUT_CYCLES(TMO)) dut_a (
    .clk(clk), .reset(reset), .m_bus(ma), .s_bus(sa),
    .grant(grant_a), .busy(busy_a), .timeout_err(terr_a)
  );

  mem_native_arbiter #(.NUM_MASTERS(N), .ARB_MODE(ARB_FIXED), .TIMEOUT_CYCLES(0)) dut_b (
    .clk(clk), .reset(reset), .m_bus(mb), .s_bus(sb),
    .grant(grant_b), .busy(busy_b), .timeout_err(terr_b)
  );

  assign mb.valid = ma.valid;
  assign mb.instr = ma.instr;
  assign mb.addr  = ma.addr;
  assign mb.wdata = ma.wdata;
  assign mb.wstrb = ma.wstrb;
  assign sb.ready = sa.ready;
  assign sb.rdata = sa.rdata;

  logic        req_v [N];
  logic [31:0] req_a [N];
  logic [31:0] req_d [N];
  logic [3:0]  req_s [N];
  logic        req_i [N];
  int          rr_ptr;
  logic        exp_terr;
  logic        in_done;
  int          total = 0;
  int          bad   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input int m, input logic v, input logic [31:0] a,
                         input logic [31:0] d, input logic [3:0] s, input logic i);
    req_v[m] = v; req_a[m] = a; req_d[m] = d; req_s[m] = s; req_i[m] = i;
    ma.valid[m]          = v;
    ma.addr[32*m +: 32]  = a;
    ma.wdata[32*m +: 32] = d;
    ma.wstrb[4*m +: 4]   = s;
    ma.instr[m]          = i;
  endtask

  task automatic set_rand_req(input int m);
    set_req(m, 1'b1, $urandom(), $urandom(), 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
  endtask

  // Reference rules: RR takes the first requester after the last winner, fixed the lowest index.
  function automatic int rr_pick();
    for (int k = 1; k <= N; k++) begin
      if (req_v[(rr_ptr + k) % N]) return (rr_ptr + k) % N;
    end
    return -1;
  endfunction

  function automatic int fixed_pick();
    for (int k = 0; k < N; k++) begin
      if (req_v[k]) return k;
    end
    return -1;
  endfunction

  // One whole transaction: arbitration, dly un-ready BUSY cycles (or a timeout), completion.
  task automatic run_txn(input int dly, input logic [31:0] rd, input bit tmo,
                         input bit keep, input bit chk_b, input string tag);
    int          m;
    int          w;
    int          fb;
    logic [31:0] exp_rd;
    if (in_done) begin
      sa.ready = 1'($urandom_range(0, 1));
      sa.rdata = $urandom();
      @(negedge clk);
      chk({tag, "_ready_cleared"}, 32'(ma.ready), 32'd0);
      chk({tag, "_idle_busy"}, 32'(busy_a), 32'd0);
    end
    sa.ready = 1'($urandom_range(0, 1));
    sa.rdata = $urandom();
    m  = rr_pick();
    fb = fixed_pick();
    rr_ptr = m;
    @(negedge clk);
    chk({tag, "_grant"}, 32'(grant_a), 32'(m));
    chk({tag, "_s_valid"}, 32'(sa.valid), 32'd1);
    chk({tag, "_s_addr"}, sa.addr, req_a[m]);
    chk({tag, "_s_wdata"}, sa.wdata, req_d[m]);
    chk({tag, "_s_wstrb"}, 32'(sa.wstrb), 32'(req_s[m]));
    chk({tag, "_s_instr"}, 32'(sa.instr), 32'(req_i[m]));
    chk({tag, "_busy"}, 32'(busy_a), 32'd1);
    chk({tag, "_terr_hold"}, 32'(terr_a), 32'(exp_terr));
    if (chk_b) chk({tag, "_b_grant"}, 32'(grant_b), 32'(fb));
    w = tmo ? TMO : dly + 1;
    sa.ready = (!tmo && dly == 0);
    sa.rdata = rd;
    for (int c = 2; c <= w; c++) begin
      @(negedge clk);
      chk({tag, "_wait_valid"}, 32'(sa.valid), 32'd1);
      chk({tag, "_wait_addr"}, sa.addr, req_a[m]);
      chk({tag, "_wait_noready"}, 32'(ma.ready), 32'd0);
      sa.ready = (!tmo && c == dly + 1);
    end
    @(negedge clk);
    if (tmo) exp_terr = 1'b1;
    exp_rd = tmo ? TIMEOUT_RDATA : rd;
    chk({tag, "_m_ready"}, 32'(ma.ready), 32'd1 << m);
    chk({tag, "_m_rdata"}, ma.rdata, exp_rd);
    chk({tag, "_s_valid_drop"}, 32'(sa.valid), 32'd0);
    chk({tag, "_done_busy"}, 32'(busy_a), 32'd1);
    chk({tag, "_terr"}, 32'(terr_a), 32'(exp_terr));
    if (chk_b) begin
      chk({tag, "_b_m_ready"}, 32'(mb.ready), 32'd1 << fb);
      chk({tag, "_b_m_rdata"}, mb.rdata, rd);
    end
    sa.ready = 1'b0;
    if (!keep) begin
      req_v[m]    = 1'b0;
      ma.valid[m] = 1'b0;
    end
    in_done = 1'b1;
  endtask

  initial begin
    reset    = 1'b1;
    ma.valid = '0; ma.instr = '0; ma.addr = '0; ma.wdata = '0; ma.wstrb = '0;
    sa.ready = 1'b0; sa.rdata = 32'h0;
    for (int m = 0; m < N; m++) set_req(m, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0);
    rr_ptr   = N - 1;
    exp_terr = 1'b0;
    in_done  = 1'b0;

    @(negedge clk);
    chk("rst_s_valid", 32'(sa.valid), 32'd0);
    chk("rst_s_instr", 32'(sa.instr), 32'd0);
    chk("rst_s_addr", sa.addr, 32'd0);
    chk("rst_s_wdata", sa.wdata, 32'd0);
    chk("rst_s_wstrb", 32'(sa.wstrb), 32'd0);
    chk("rst_m_ready", 32'(ma.ready), 32'd0);
    chk("rst_m_rdata", ma.rdata, 32'd0);
    chk("rst_grant", 32'(grant_a), 32'd0);
    chk("rst_busy", 32'(busy_a), 32'd0);
    chk("rst_terr", 32'(terr_a), 32'd0);
    reset = 1'b0;
    @(negedge clk);

    set_req(0, 1'b1, 32'h0000_0100, 32'h0, 4'b0000, 1'b0);
    run_txn(2, 32'h1234_5678, 1'b0, 1'b0, 1'b1, "m0_read");

    set_req(1, 1'b1, 32'h0000_0200, 32'hAABB_CCDD, 4'b0011, 1'b0);
    run_txn($urandom_range(0, 4), $urandom(), 1'b0, 1'b0, 1'b1, "m1_write");

    set_req(0, 1'b1, 32'h0000_1000, 32'h1111_1111, 4'b1111, 1'b1);
    set_req(1, 1'b1, 32'h0000_2000, 32'h2222_2222, 4'b0000, 1'b0);
    for (int t = 0; t < 4; t++) run_txn(0, $urandom(), 1'b0, 1'b1, 1'b1, "both_hold");
    req_v[0] = 1'b0; ma.valid[0] = 1'b0;
    req_v[1] = 1'b0; ma.valid[1] = 1'b0;

    set_req(0, 1'b1, 32'h0000_0300, 32'h0, 4'b0000, 1'b0);
    run_txn(TMO - 1, 32'h55AA_55AA, 1'b0, 1'b0, 1'b1, "ready_at_limit");

    set_req(1, 1'b1, 32'h0000_0400, 32'h0, 4'b0000, 1'b1);
    run_txn(0, 32'h0, 1'b1, 1'b0, 1'b0, "timeout");

    for (int t = 0; t < 20; t++) begin
      for (int m = 0; m < N; m++) begin
        if (!req_v[m] && $urandom_range(0, 1) == 1) set_rand_req(m);
      end
      if (!req_v[0] && !req_v[1]) set_rand_req($urandom_range(0, N - 1));
      run_txn($urandom_range(0, 6), $urandom(), ($urandom_range(0, 7) == 0),
              1'b0, 1'b0, "rnd");
    end

    set_req(0, 1'b1, 32'h0000_5000, 32'h5555_0000, 4'b1000, 1'b0);
    set_req(1, 1'b1, 32'h0000_6000, 32'h6666_0000, 4'b0100, 1'b0);
    @(negedge clk);
    @(negedge clk);
    chk("pre_rst_busy", 32'(busy_a), 32'd1);
    #2 reset = 1'b1;
    #1;
    chk("async_rst_s_valid", 32'(sa.valid), 32'd0);
    chk("async_rst_busy", 32'(busy_a), 32'd0);
    chk("async_rst_m_ready", 32'(ma.ready), 32'd0);
    chk("async_rst_grant", 32'(grant_a), 32'd0);
    chk("async_rst_terr", 32'(terr_a), 32'd0);
    chk("async_rst_b_busy", 32'(busy_b), 32'd0);
    chk("async_rst_b_terr", 32'(terr_b), 32'd0);
    @(negedge clk);
    reset    = 1'b0;
    rr_ptr   = N - 1;
    exp_terr = 1'b0;
    in_done  = 1'b0;
    run_txn($urandom_range(0, 3), $urandom(), 1'b0, 1'b0, 1'b1, "post_rst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
